iob_fifo_wr_arb: RTL and testbench
==================================

# iob_fifo_wr_arb

Write-port arbiter that shares the single write port of one FIFO (sync or async write side) among N_REQ requesters. Round-robin grants with bounded bursts; a word transfers only while the FIFO is not full. Sits in the write-clock domain, between the requester blocks and the FIFO `w_en`/`w_data`/`w_full` pins.

## Interface
Parameters:
- N_REQ, 4, number of requesters (>=2).
- DATA_W, 8, word width; equals FIFO W_DATA_W.
- MAX_BURST, 4, max words per grant (>=1); counter width $clog2(MAX_BURST)+1.

Ports:
- clk  in  1  write-side clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  N_REQ  req[i]=1: requester i has a valid word on its data slice.
- data  in  N_REQ*DATA_W  requester i word at data[i*DATA_W +: DATA_W].
- ack  out  N_REQ  ack[i]=1: word from i written this cycle; requester advances on the edge.
- grant  out  N_REQ  registered one-hot current owner; 0 when idle.
- busy  out  1  FSM in BURST.
- w_en  out  1  FIFO write enable.
- w_data  out  DATA_W  FIFO write data.
- w_full  in  1  FIFO full flag (write domain).

## Operation
- State: FSM {IDLE, BURST}, rr_ptr (index, $clog2(N_REQ) bits), owner index g, burst count cnt.
- IDLE: if any req, select first i with req[i]=1 scanning rr_ptr, rr_ptr+1, ... mod N_REQ; load g=i, cnt=0, grant=onehot(i), go BURST. No req: stay IDLE, grant=0.
- BURST: ack[g] = req[g] & ~w_full; all other ack bits 0. w_en = |ack. w_data = data slice g (don't-care when w_en=0, drive the slice anyway).
- On each ack: cnt=cnt+1. If cnt+1 == MAX_BURST, release.
- If req[g]=0 in a BURST cycle: release (no write that cycle).
- w_full=1 with req[g]=1: stall; hold grant, cnt frozen, no release.
- Release: next state IDLE, grant=0, rr_ptr=(g+1) mod N_REQ (wrap from N_REQ-1 to 0).
- A requester must hold req and data stable until ack; dropping req forfeits the grant.
- Reset (any time, incl. mid-burst): FSM=IDLE, rr_ptr=0, cnt=0; grant=0, busy=0, ack=0, w_en=0 immediately. Words in flight are not written.

## Timing
- Reset values: grant=0, busy=0, ack=0, w_en=0, w_data=data slice 0 (no meaning).
- ack, w_en, w_data combinational from registered state plus req/w_full; no register between w_full and w_en, so no overflow.
- Arbitration latency: req seen in IDLE at edge k -> grant at k, first ack earliest cycle k..k+1 (1 cycle after IDLE sample).
- Throughput: MAX_BURST words per MAX_BURST+1 cycles per owner (1 IDLE bubble per release).
- Release on MAX_BURST-th ack and req drop both take effect next edge.

## Configuration
- IOB_FIFO_WR_ARB_PRIO_EN defined: fixed priority; IDLE selects lowest index i with req[i]=1; rr_ptr not updated (held at 0). Burst limit still applies.
- Undefined: round-robin as in Operation.

## Test plan
(N_REQ=4, DATA_W=8, MAX_BURST=4)
- Reset: rst_n=0 mid-burst with req=4'b0001 -> grant, ack, w_en, busy drop to 0 without waiting for clk; after rst_n=1 first grant goes to requester 0.
- Single requester: req[0] held, data 0x00,0x01,... on each ack, w_full=0 -> w_en pattern 1,1,1,1,0 repeating; FIFO receives 0x00..0x0F in order after 20 cycles.
- Round-robin: req=4'b0101 continuous -> grant order 0,2,0,2; exactly 4 words each; never two owners in one cycle.
- Full stall: req[1] held, w_full=1 for 3 cycles after second word -> ack[1]=0 and w_en=0 those 3 cycles, grant holds 4'b0010; burst still ends after 4 words total.
- Req drop: req[3] drops after 2 acks with req[0] pending -> release next edge, rr_ptr wraps to 0, requester 0 granted next.
- PRIO_EN build: req=4'b1010 continuous -> requester 1 granted every burst; requester 3 granted only when req[1]=0.

Source files
------------

// File: rtl/iob_fifo_wr_arb.sv
// iob_fifo_wr_arb: shares the single write port of one FIFO among N_REQ
// requesters. The arbiter grants one requester at a time in round-robin
// order. Each grant carries a burst of at most MAX_BURST words. A word is
// written only while the FIFO is not full.
//
// Build option IOB_FIFO_WR_ARB_PRIO_EN (undefined by default): when defined,
// the arbiter uses fixed priority instead, so the lowest-indexed active
// requester wins every arbitration. The round-robin pointer then stays at 0.
// The burst limit still applies.
module iob_fifo_wr_arb #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] data,
  output logic [N_REQ-1:0]        ack,
  output logic [N_REQ-1:0]        grant,
  output logic                    busy,
  output logic                    w_en,
  output logic [DATA_W-1:0]       w_data,
  input  logic                    w_full
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;   // first index examined at the next arbitration
  logic [IDX_W-1:0] g;        // current owner index
  logic [CNT_W-1:0] cnt;      // words already written in this burst
  logic [IDX_W-1:0] sel_idx;
  logic             any_req;
  logic             rel;

  // Pick the first active requester, scanning upward from rr_ptr with wrap.
  // The fixed-priority build never moves rr_ptr off 0, so this same scan
  // returns the lowest active index in that build.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; otherwise the tool infers a latch.
    sel_idx = '0;
    any_req = 1'b0;
    // Walk the scan order backwards so the earliest match is written last.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      int j;
      j = int'(rr_ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (req[j]) begin
        sel_idx = IDX_W'(j);
        any_req = 1'b1;
      end
    end
  end

  // Acknowledge the owner's word whenever it is presented and the FIFO has room.
  always_comb begin
    ack = '0;
    if (state == BURST && req[g] && !w_full) ack[g] = 1'b1;
  end

  // There is no register between w_full and w_en, so a write is never issued
  // into a full FIFO.
  assign w_en   = |ack;
  assign w_data = data[g*DATA_W +: DATA_W];

  // The burst ends when the owner drops req. It also ends when the owner's
  // word written in this cycle is the last one the burst allows.
  assign rel = (state == BURST) && (!req[g] || (!w_full && cnt == CNT_LAST));

  // Arbitration FSM with registered grant and busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rr_ptr <= '0;
      g      <= '0;
      cnt    <= '0;
      grant  <= '0;
      busy   <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      case (state)
        IDLE: begin
          if (any_req) begin
            g     <= sel_idx;
            cnt   <= '0;
            grant <= {{(N_REQ-1){1'b0}}, 1'b1} << sel_idx;
            busy  <= 1'b1;
            state <= BURST;
          end
        end
        BURST: begin
          if (rel) begin
            state <= IDLE;
            grant <= '0;
            busy  <= 1'b0;
            cnt   <= '0;
`ifdef IOB_FIFO_WR_ARB_PRIO_EN
            rr_ptr <= '0;
`else
            rr_ptr <= (g == IDX_LAST) ? '0 : g + 1'b1;
`endif
          end else if (req[g] && !w_full) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iob_fifo_wr_arb.sv
// Self-checking bench for iob_fifo_wr_arb (N_REQ=4, DATA_W=8, MAX_BURST=4).
// A cycle-level behavioural model (owner / count / pointer held as plain ints)
// predicts every output on every cycle. Directed scenarios add hand-computed
// expectations, and a randomized phase follows them.
module tb_iob_fifo_wr_arb;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*DW-1:0] data;
  logic [N-1:0]    ack;
  logic [N-1:0]    grant;
  logic            busy;
  logic            w_en;
  logic [DW-1:0]   w_data;
  logic            w_full;

  iob_fifo_wr_arb #(.N_REQ(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .data   (data),
    .ack    (ack),
    .grant  (grant),
    .busy   (busy),
    .w_en   (w_en),
    .w_data (w_data),
    .w_full (w_full)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Requester word counters: requester i presents nxt[i] and advances on ack.
  int nxt [N];

  // Outputs sampled at the falling edge of the current step.
  logic [N-1:0]  s_grant;
  logic [N-1:0]  s_ack;
  logic          s_busy;
  logic          s_wen;
  logic [DW-1:0] s_wdata;

  // Behavioural model: owner index (-1 when idle), words written, scan start.
  int m_owner;
  int m_cnt;
  int m_ptr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_data();
    for (int i = 0; i < N; i++) data[i*DW +: DW] = nxt[i][DW-1:0];
  endtask

  function automatic int pick(input logic [N-1:0] r);
    int start;
`ifdef IOB_FIFO_WR_ARB_PRIO_EN
    start = 0;
`else
    start = m_ptr;
`endif
    for (int k = 0; k < N; k++) begin
      if (r[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  task automatic model_release();
`ifdef IOB_FIFO_WR_ARB_PRIO_EN
    m_ptr = 0;
`else
    m_ptr = (m_owner + 1) % N;
`endif
    m_owner = -1;
  endtask

  task automatic model_update();
    if (m_owner < 0) begin
      int p;
      p = pick(req);
      if (p >= 0) begin
        m_owner = p;
        m_cnt   = 0;
      end
    end else if (!req[m_owner]) begin
      model_release();
    end else if (!w_full) begin
      m_cnt++;
      if (m_cnt == MB) model_release();
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_cnt   = 0;
    m_ptr   = 0;
  endtask

  // One clock cycle: sample and compare at the falling edge, advance the
  // model at the rising edge, then let requesters react to their ack.
  task automatic step();
    logic [N-1:0] e_grant;
    logic [N-1:0] e_ack;
    @(negedge clk);
    s_grant = grant;
    s_ack   = ack;
    s_busy  = busy;
    s_wen   = w_en;
    s_wdata = w_data;
    e_grant = '0;
    e_ack   = '0;
    if (m_owner >= 0) begin
      e_grant = N'(1) << m_owner;
      if (req[m_owner] && !w_full) e_ack = e_grant;
    end
    check("cyc_grant", 32'(s_grant), 32'(e_grant));
    check("cyc_busy",  32'(s_busy),  32'(m_owner >= 0));
    check("cyc_ack",   32'(s_ack),   32'(e_ack));
    check("cyc_w_en",  32'(s_wen),   32'(e_ack != '0));
    if (e_ack != '0) check("cyc_w_data", 32'(s_wdata), 32'(data[m_owner*DW +: DW]));
    @(posedge clk);
    model_update();
    #1;
    for (int i = 0; i < N; i++) if (s_ack[i]) nxt[i]++;
    set_data();
  endtask

  // Synchronised reset between scenarios: called just after a rising edge.
  task automatic do_reset();
    rst_n  = 1'b0;
    req    = '0;
    w_full = 1'b0;
    for (int i = 0; i < N; i++) nxt[i] = 0;
    set_data();
    model_reset();
    #10;
    rst_n = 1'b1;
  endtask

  function automatic int idx_of(input logic [N-1:0] oh);
    for (int i = 0; i < N; i++) if (oh[i]) return i;
    return -1;
  endfunction

  initial begin
    logic [DW-1:0] words[$];
    int            owners[$];
    int            bad;
    int            acks [N];
    logic [N-1:0]  prev;

    rst_n  = 1'b0;
    req    = '0;
    w_full = 1'b0;
    for (int i = 0; i < N; i++) nxt[i] = 0;
    set_data();
    model_reset();
    #13;
    rst_n = 1'b1;
    #1;
    check("rst_grant", 32'(grant), 32'(0));
    check("rst_busy",  32'(busy),  32'(0));
    check("rst_ack",   32'(ack),   32'(0));
    check("rst_w_en",  32'(w_en),  32'(0));
    @(posedge clk);
    #1;

    // Reset mid-burst: outputs drop at once, then requester 0 is granted again.
    req = 4'b0001;
    step();
    step();
    check("midrst_pre_ack", 32'(s_ack), 32'(4'b0001));
    rst_n = 1'b0;
    #1;
    check("midrst_grant", 32'(grant), 32'(0));
    check("midrst_ack",   32'(ack),   32'(0));
    check("midrst_w_en",  32'(w_en),  32'(0));
    check("midrst_busy",  32'(busy),  32'(0));
    model_reset();
    #10;
    rst_n = 1'b1;
    step();
    step();
    check("midrst_regrant", 32'(s_grant), 32'(4'b0001));

    // Single requester: w_en goes 0,1,1,1,1 per five cycles and the words
    // arrive in order.
    @(posedge clk);
    #1;
    do_reset();
    req = 4'b0001;
    words.delete();
    for (int c = 1; c <= 20; c++) begin
      step();
      check("single_wen_pattern", 32'(s_wen), 32'((c % 5) != 1));
      if (s_wen) words.push_back(s_wdata);
    end
    check("single_word_count", 32'(words.size()), 32'(16));
    for (int i = 0; i < words.size(); i++) check("single_word_val", 32'(words[i]), 32'(i));

    // Round-robin between requesters 0 and 2.
    do_reset();
    req = 4'b0101;
    owners.delete();
    bad  = 0;
    prev = '0;
    for (int i = 0; i < N; i++) acks[i] = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (!$onehot0(s_grant)) bad++;
      if (prev == '0 && s_grant != '0) owners.push_back(idx_of(s_grant));
      for (int i = 0; i < N; i++) if (s_ack[i]) acks[i]++;
      prev = s_grant;
    end
    check("rr_onehot_violations", 32'(bad), 32'(0));
    check("rr_burst_count", 32'(owners.size()), 32'(4));
    if (owners.size() == 4) begin
      check("rr_owner0", 32'(owners[0]), 32'(0));
      check("rr_owner1", 32'(owners[1]), 32'(2));
      check("rr_owner2", 32'(owners[2]), 32'(0));
      check("rr_owner3", 32'(owners[3]), 32'(2));
    end
    check("rr_words_req0", 32'(acks[0]), 32'(8));
    check("rr_words_req2", 32'(acks[2]), 32'(8));

    // Full stall after the second word of requester 1's burst.
    do_reset();
    req = 4'b0010;
    step();
    step();
    check("stall_w0_ack", 32'(s_ack), 32'(4'b0010));
    step();
    check("stall_w1_data", 32'(s_wdata), 32'(1));
    w_full = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check("stall_ack",   32'(s_ack),   32'(0));
      check("stall_w_en",  32'(s_wen),   32'(0));
      check("stall_grant", 32'(s_grant), 32'(4'b0010));
    end
    w_full = 1'b0;
    step();
    check("stall_w2_data", 32'(s_wdata), 32'(2));
    step();
    check("stall_w3_grant", 32'(s_grant), 32'(4'b0010));
    check("stall_w3_data",  32'(s_wdata), 32'(3));
    step();
    check("stall_released", 32'(s_grant), 32'(0));

    // Requester 3 drops req after two words while requester 0 waits.
    do_reset();
    req = 4'b1000;
    step();
    req = 4'b1001;
    step();
    check("drop_grant3", 32'(s_grant), 32'(4'b1000));
    step();
    req = 4'b0001;
    step();
    check("drop_no_ack",  32'(s_ack),   32'(0));
    check("drop_no_w_en", 32'(s_wen),   32'(0));
    step();
    check("drop_idle", 32'(s_grant), 32'(0));
    step();
    check("drop_next_owner", 32'(s_grant), 32'(4'b0001));

    // req=4'b1010: fixed priority keeps requester 1, round-robin alternates.
    do_reset();
    req = 4'b1010;
    owners.delete();
    prev = '0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (prev == '0 && s_grant != '0) owners.push_back(idx_of(s_grant));
      prev = s_grant;
    end
    check("mode_burst_count", 32'(owners.size()), 32'(4));
    if (owners.size() == 4) begin
`ifdef IOB_FIFO_WR_ARB_PRIO_EN
      for (int i = 0; i < 4; i++) check("prio_owner", 32'(owners[i]), 32'(1));
`else
      for (int i = 0; i < 4; i++) check("rr13_owner", 32'(owners[i]), 32'((i % 2 == 0) ? 1 : 3));
`endif
    end
    do_reset();
    req = 4'b1000;
    step();
    step();
    check("mode_req3_alone", 32'(s_grant), 32'(4'b1000));

    // Randomized traffic. Requesters hold req until ack and occasionally
    // forfeit the grant. The FIFO is full about a quarter of the time.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      w_full = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          if (s_ack[i]) req[i] = ($urandom_range(0, 3) != 0);
          else if ($urandom_range(0, 31) == 0) req[i] = 1'b0;
        end else begin
          req[i] = ($urandom_range(0, 2) == 0);
        end
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
